// File: rtl/cpu_dmem_pkg.sv
// Shared constants and FSM state type for the CPU data-memory responder.
package cpu_dmem_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        HOST  = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_dmem_array.sv
// 2**AW x DW storage: one synchronous write port, combinational CPU and host read ports.
module cpu_dmem_array #(
    parameter int unsigned DW = cpu_dmem_pkg::DW,
    parameter int unsigned AW = cpu_dmem_pkg::AW
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] cpu_raddr,
    output logic [DW-1:0] cpu_rdata_c,
    input  logic [AW-1:0] host_raddr,
    output logic [DW-1:0] host_rdata_c
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign cpu_rdata_c  = mem[cpu_raddr];
    assign host_rdata_c = mem[host_raddr];

endmodule

// File: rtl/cpu_dmem_responder.sv
// Data-memory responder: CPU load/store port, host load/dump handshake and hardware clear.
// Optional store/transfer counters are built when CPU_DMEM_STATS_EN is defined.
module cpu_dmem_responder #(
    parameter int unsigned DW = cpu_dmem_pkg::DW,
    parameter int unsigned AW = cpu_dmem_pkg::AW
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [AW-1:0]                d_addr,
    input  logic [DW-1:0]                d_dataout,
    input  logic                         d_we,
    output logic [DW-1:0]                d_datain,
    input  logic                         cpu_run,
    input  logic                         clear_start,
    output logic                         busy,
    input  logic                         host_req,
    input  logic                         host_we,
    input  logic [AW-1:0]                host_addr,
    input  logic [DW-1:0]                host_wdata,
    output logic                         host_ack,
    output logic [DW-1:0]                host_rdata,
    output logic                         err,
    output logic [cpu_dmem_pkg::CNT_W-1:0] cpu_wr_count,
    output logic [cpu_dmem_pkg::CNT_W-1:0] host_xfer_count
);

    import cpu_dmem_pkg::state_t;
    import cpu_dmem_pkg::IDLE;
    import cpu_dmem_pkg::CLEAR;
    import cpu_dmem_pkg::HOST;

    localparam int unsigned CNT_W = cpu_dmem_pkg::CNT_W;

    state_t        state, state_n;
    logic [AW-1:0] clr_addr, clr_addr_n;
    logic          host_done;
    logic          err_set;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] cpu_rd_c;
    logic [DW-1:0] host_rd_c;

    cpu_dmem_array #(.DW(DW), .AW(AW)) u_array (
        .clock        (clock),
        .we           (mem_we),
        .waddr        (mem_waddr),
        .wdata        (mem_wdata),
        .cpu_raddr    (d_addr),
        .cpu_rdata_c  (cpu_rd_c),
        .host_raddr   (host_addr),
        .host_rdata_c (host_rd_c)
    );

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            clr_addr   <= '0;
            busy       <= 1'b0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
            err        <= 1'b0;
        end else begin
            state    <= state_n;
            clr_addr <= clr_addr_n;
            busy     <= (state_n == CLEAR);
            host_ack <= host_done;
            if (host_done && !host_we) begin
                host_rdata <= host_rd_c;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Next state and write-port arbitration; a clear sweep owns the port outright
    always_comb begin
        state_n    = state;
        clr_addr_n = clr_addr;
        host_done  = 1'b0;
        err_set    = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = d_addr;
        mem_wdata  = d_dataout;

        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_n    = CLEAR;
                    clr_addr_n = '0;
                end else if (host_req && !cpu_run) begin
                    state_n = HOST;
                end
            end
            CLEAR: begin
                clr_addr_n = clr_addr + AW'(1);
                if (&clr_addr) begin
                    state_n = IDLE;
                end
            end
            HOST: begin
                host_done = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
            err_set   = d_we;
        end else if (d_we) begin
            mem_we  = 1'b1;
            err_set = (state == HOST);
        end else if ((state == HOST) && host_we) begin
            mem_we    = 1'b1;
            mem_waddr = host_addr;
            mem_wdata = host_wdata;
        end

        if (reset) begin
            mem_we = 1'b0;
        end
    end

    assign d_datain = (reset || busy) ? '0 : cpu_rd_c;

`ifdef CPU_DMEM_STATS_EN
    logic cpu_store_ok;
    assign cpu_store_ok = d_we && (state != CLEAR);

    // Saturating activity counters
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_wr_count    <= '0;
            host_xfer_count <= '0;
        end else begin
            if (cpu_store_ok && (cpu_wr_count != '1)) begin
                cpu_wr_count <= cpu_wr_count + CNT_W'(1);
            end
            if (host_done && (host_xfer_count != '1)) begin
                host_xfer_count <= host_xfer_count + CNT_W'(1);
            end
        end
    end
`else
    assign cpu_wr_count    = '0;
    assign host_xfer_count = '0;
`endif

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Self-checking bench for cpu_dmem_responder: directed scenarios plus randomized traffic
// checked every cycle against a behavioural memory/transaction model.
`timescale 1ns/1ps
module tb_cpu_dmem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  d_addr = '0;
    logic [15:0] d_dataout = '0;
    logic        d_we = 1'b0;
    logic [15:0] d_datain;
    logic        cpu_run = 1'b0;
    logic        clear_start = 1'b0;
    logic        busy;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        err;
    logic [15:0] cpu_wr_count;
    logic [15:0] host_xfer_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cpu_dmem_responder dut (
        .clock           (clock),
        .reset           (reset),
        .d_addr          (d_addr),
        .d_dataout       (d_dataout),
        .d_we            (d_we),
        .d_datain        (d_datain),
        .cpu_run         (cpu_run),
        .clear_start     (clear_start),
        .busy            (busy),
        .host_req        (host_req),
        .host_we         (host_we),
        .host_addr       (host_addr),
        .host_wdata      (host_wdata),
        .host_ack        (host_ack),
        .host_rdata      (host_rdata),
        .err             (err),
        .cpu_wr_count    (cpu_wr_count),
        .host_xfer_count (host_xfer_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: memory image, remaining clear cycles, pending host transaction
    logic [15:0] m_mem [256];
    bit          m_known [256];
    int          clr_left = 0;
    bit          host_pend = 0;
    bit          m_ack = 0;
    logic [15:0] m_rdata = '0;
    bit          m_rdata_known = 1;
    bit          m_err = 0;
    int          m_wr = 0;
    int          m_xfer = 0;

    always @(posedge clock) begin
        if (reset) begin
            clr_left      = 0;
            host_pend     = 0;
            m_ack         = 0;
            m_rdata       = '0;
            m_rdata_known = 1;
            m_err         = 0;
            m_wr          = 0;
            m_xfer        = 0;
        end else begin
            m_ack = 0;
            if (clr_left > 0) begin
                m_mem[256 - clr_left]   = '0;
                m_known[256 - clr_left] = 1;
                if (d_we) m_err = 1;
                clr_left--;
            end else if (host_pend) begin
                host_pend = 0;
                m_ack     = 1;
                m_xfer    = (m_xfer < 65535) ? m_xfer + 1 : 65535;
                if (!host_we) begin
                    m_rdata       = m_mem[host_addr];
                    m_rdata_known = m_known[host_addr];
                end
                if (d_we) begin
                    m_mem[d_addr]   = d_dataout;
                    m_known[d_addr] = 1;
                    m_wr            = (m_wr < 65535) ? m_wr + 1 : 65535;
                    m_err           = 1;
                end else if (host_we) begin
                    m_mem[host_addr]   = host_wdata;
                    m_known[host_addr] = 1;
                end
            end else begin
                if (d_we) begin
                    m_mem[d_addr]   = d_dataout;
                    m_known[d_addr] = 1;
                    m_wr            = (m_wr < 65535) ? m_wr + 1 : 65535;
                end
                if (clear_start) clr_left = 256;
                else if (host_req && !cpu_run) host_pend = 1;
            end
        end
        #1;
        chk("busy", 32'(busy), 32'(clr_left > 0));
        chk("host_ack", 32'(host_ack), 32'(m_ack));
        chk("err", 32'(err), 32'(m_err));
        if (m_rdata_known) chk("host_rdata", 32'(host_rdata), 32'(m_rdata));
        if (reset || clr_left > 0) chk("d_datain_forced", 32'(d_datain), 32'd0);
        else if (m_known[d_addr]) chk("d_datain", 32'(d_datain), 32'(m_mem[d_addr]));
`ifdef CPU_DMEM_STATS_EN
        chk("cpu_wr_count", 32'(cpu_wr_count), 32'(m_wr));
        chk("host_xfer_count", 32'(host_xfer_count), 32'(m_xfer));
`else
        chk("cpu_wr_count", 32'(cpu_wr_count), 32'd0);
        chk("host_xfer_count", 32'(host_xfer_count), 32'd0);
`endif
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Raise a host request and return the number of edges until ack is seen
    task automatic host_xfer(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                             output int n);
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        host_req   = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!host_ack && n < 40);
        host_req = 1'b0;
    endtask

    task automatic wait_clear_done();
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("clear_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int acks;
        logic [15:0] exp_wr;
        logic [15:0] exp_xfer;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(host_ack), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wr_count", 32'(cpu_wr_count), 32'd0);

        // Clear: busy for exactly 256 cycles, then every location reads zero
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            n++;
            tick();
        end
        chk("clear_len", 32'(n), 32'd256);
        for (int a = 0; a < 256; a++) begin
            d_addr = 8'(a);
            #1;
            chk("sweep_zero", 32'(d_datain), 32'd0);
        end
        tick();

        // CPU store then load
        d_we = 1'b1; d_addr = 8'h08; d_dataout = 16'hAA55;
        tick();
        d_we = 1'b0;
        #1;
        chk("cpu_store_load", 32'(d_datain), 32'h0000AA55);
`ifdef CPU_DMEM_STATS_EN
        exp_wr = 16'd1; exp_xfer = 16'd2;
`else
        exp_wr = 16'd0; exp_xfer = 16'd0;
`endif
        chk("wr_count_1", 32'(cpu_wr_count), 32'(exp_wr));

        // Host write then read
        host_xfer(1'b1, 8'h7F, 16'h1234, n);
        chk("host_wr_latency", 32'(n), 32'd2);
        host_xfer(1'b0, 8'h7F, 16'h0000, n);
        chk("host_rd_latency", 32'(n), 32'd2);
        chk("host_rd_data", 32'(host_rdata), 32'h00001234);
        chk("xfer_count_2", 32'(host_xfer_count), 32'(exp_xfer));
        tick();

        // Host blocked while CPU runs
        cpu_run = 1'b1;
        host_we = 1'b0; host_addr = 8'h7F; host_req = 1'b1;
        acks = 0;
        repeat (10) begin
            tick();
            if (host_ack) acks++;
        end
        chk("blocked_no_ack", 32'(acks), 32'd0);
        cpu_run = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!host_ack && n < 40);
        host_req = 1'b0;
        chk("unblock_latency", 32'(n), 32'd2);
        tick();

        // CPU store during clear is dropped and flagged
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (4) tick();
        d_we = 1'b1; d_addr = 8'h01; d_dataout = 16'h5A5A;
        tick();
        d_we = 1'b0;
        chk("conflict_err", 32'(err), 32'd1);
        wait_clear_done();
        chk("conflict_err_sticky", 32'(err), 32'd1);
        d_addr = 8'h01;
        #1;
        chk("conflict_dropped", 32'(d_datain), 32'd0);
        chk("conflict_wr_count", 32'(cpu_wr_count), 32'(exp_wr));

        // Reset mid-clear leaves the array partially cleared
        d_we = 1'b1; d_addr = 8'hC0; d_dataout = 16'hBEEF;
        tick();
        d_we = 1'b0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (99) tick();
        reset = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        d_addr = 8'hC0;
        #1;
        chk("abort_retain", 32'(d_datain), 32'h0000BEEF);
        chk("abort_err_clr", 32'(err), 32'd0);
        chk("abort_wr_count", 32'(cpu_wr_count), 32'd0);
        tick();

        // Randomized traffic under the host handshake protocol
        for (int c = 0; c < 4000; c++) begin
            d_addr      = 8'($urandom);
            d_dataout   = 16'($urandom);
            d_we        = ($urandom_range(0, 3) == 0);
            clear_start = ($urandom_range(0, 799) == 0);
            reset       = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 49) == 0) cpu_run = ~cpu_run;
            if (host_req) begin
                if (host_ack) host_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = 8'($urandom);
                host_wdata = 16'($urandom);
                host_req   = 1'b1;
            end
            tick();
        end
        d_we = 1'b0;
        clear_start = 1'b0;
        reset = 1'b0;
        host_req = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
